// File: rtl/package_feeder_pkg.sv
// Shared definitions for the package weight bus: sort group thresholds,
// group encodings, the feeder FSM states and the weight-to-group mapping.
package package_feeder_pkg;

  localparam logic [11:0] GRP1_MAX = 12'd250;
  localparam logic [11:0] GRP2_MAX = 12'd500;
  localparam logic [11:0] GRP3_MAX = 12'd750;
  localparam logic [11:0] GRP4_MAX = 12'd1000;
  localparam logic [11:0] GRP5_MAX = 12'd2000;

  localparam logic [2:0] GRP_NONE = 3'd0;
  localparam logic [2:0] GRP1     = 3'd1;
  localparam logic [2:0] GRP2     = 3'd2;
  localparam logic [2:0] GRP3     = 3'd3;
  localparam logic [2:0] GRP4     = 3'd4;
  localparam logic [2:0] GRP5     = 3'd5;
  localparam logic [2:0] GRP6     = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } feed_state_t;

  // Maps a weight in grams to its sort group; zero means no package.
  function automatic logic [2:0] weight_to_grp(input logic [11:0] w);
    if (w == 12'd0)          return GRP_NONE;
    else if (w <= GRP1_MAX)  return GRP1;
    else if (w <= GRP2_MAX)  return GRP2;
    else if (w <= GRP3_MAX)  return GRP3;
    else if (w <= GRP4_MAX)  return GRP4;
    else if (w <= GRP5_MAX)  return GRP5;
    else                     return GRP6;
  endfunction

endpackage

// File: rtl/package_feeder_fifo.sv
// package_fifo: small show-ahead FIFO holding queued package weights.
// Pushes when full and pops when empty are ignored; pointers wrap mod DEPTH.
module package_fifo
  import package_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; a simultaneous push and pop keeps level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/package_feeder.sv
// package_feeder: buffers package weights and replays them onto the weight
// bus as isolated pulses (HOLD_CYCLES nonzero, then GAP_CYCLES of zero),
// reporting the expected sort group alongside each weight.
module package_feeder
  import package_feeder_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [11:0] in_weight,
  output logic        in_ready,
  input  logic        feed_en,
  output logic [11:0] weight,
  output logic [2:0]  exp_grp,
  output logic        busy,
  output logic [3:0]  fifo_level,
  output logic [7:0]  sent_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  feed_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [11:0]   weight_n;
  logic [7:0]    sent_n;
  logic          pop;
  logic          push;
  logic          accept;
  logic          full;
  logic          empty;
  logic [11:0]   head;
  logic [LW-1:0] level;

  assign in_ready   = ~full;
  assign accept     = in_valid & ~full;
  assign push       = accept & (in_weight != 12'd0);
  assign busy       = (state != IDLE) | ~empty;
  assign fifo_level = 4'(level);

  package_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (12)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_weight),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Next-state logic: launch a package from IDLE, time the hold, then the gap.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    weight_n = weight;
    sent_n   = sent_cnt;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (feed_en && !empty) begin
          pop      = 1'b1;
          weight_n = head;
          sent_n   = sent_cnt + 8'd1;
          cnt_n    = CNT_ONE;
          state_n  = PRESENT;
        end
      end
      PRESENT: begin
        if (cnt == HOLD_LAST) begin
          weight_n = 12'd0;
          cnt_n    = CNT_ONE;
          state_n  = GAP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        weight_n = 12'd0;
        state_n  = IDLE;
      end
    endcase
  end

  // Registered bus outputs; the group is derived from the same next weight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      weight   <= 12'd0;
      exp_grp  <= GRP_NONE;
      sent_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      weight   <= weight_n;
      exp_grp  <= weight_to_grp(weight_n);
      sent_cnt <= sent_n;
    end
  end

  // Count accepted zero-weight pushes, saturating so the count stays meaningful.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (accept && (in_weight == 12'd0) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
